// File: rtl/mem_control_pkg.sv
// Shared definitions for the MEM-stage bus sequencer: state encoding, UART map, fetch filler.
package mem_control_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdSample,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StDone
  } state_e;

  localparam logic [15:0] UartDataAddr = 16'hBF00;
  localparam logic [15:0] UartStatAddr = 16'hBF01;
  localparam logic [15:0] NopInst      = 16'h0800;

  function automatic logic is_uart(input logic [15:0] addr);
    return (addr == UartDataAddr) || (addr == UartStatAddr);
  endfunction

endpackage

// File: rtl/mem_control.sv
// Arbitrates the shared SRAM/UART bus between instruction fetch (when idle) and MEM-stage
// loads/stores, sequencing strobes and pulsing done_o when a data access completes.
module mem_control
  import mem_control_pkg::*;
#(
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1,
  parameter logic [15:0] NOP_INST = NopInst
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] memAddr_i,
  input  logic [15:0] wData_i,
  input  logic        rMem_i,
  input  logic        wMem_i,
  output logic [15:0] rData_o,
  output logic        done_o,
  input  logic [15:0] ifAddr_i,
  output logic [15:0] inst_o,
  output logic [15:0] ram_addr_o,
  inout  wire  [15:0] ram_data_io,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        uart_rdn,
  output logic        uart_wrn,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  localparam logic [1:0] RdLast = 2'((RD_WAIT == 0) ? 0 : RD_WAIT - 1);
  localparam logic [1:0] WrLast = 2'((WR_PULSE == 0) ? 0 : WR_PULSE - 1);

  state_e      r_state, w_state_next;
  logic [1:0]  r_wait, w_wait_next;
  logic [15:0] r_addr, r_wdata, r_rdata, r_inst;
  logic        w_req, w_leave_idle;
  logic        w_uart, w_uart_data, w_uart_stat;
  logic        w_rd_phase, w_wr_drive, w_active;

  assign w_req        = rMem_i | wMem_i;
  assign w_leave_idle = (r_state == StIdle) && w_req;
  assign w_uart       = is_uart(r_addr);
  assign w_uart_data  = (r_addr == UartDataAddr);
  assign w_uart_stat  = (r_addr == UartStatAddr);
  assign w_rd_phase   = (r_state == StRdWait) || (r_state == StRdSample);
  assign w_wr_drive   = (r_state == StWrSetup) || (r_state == StWrPulse) ||
                        (r_state == StWrHold);
  // Reset level gates every strobe so an aborted access releases the bus at once.
  assign w_active     = rst;

  always_comb begin
    w_state_next = r_state;
    w_wait_next  = '0;
    unique case (r_state)
      StIdle: begin
        if (rMem_i) begin
          w_state_next = (RD_WAIT == 0) ? StRdSample : StRdWait;
        end else if (wMem_i) begin
          w_state_next = StWrSetup;
        end
      end
      StRdWait: begin
        if (r_wait == RdLast) w_state_next = StRdSample;
        else                  w_wait_next  = r_wait + 2'd1;
      end
      StRdSample: w_state_next = StDone;
      StWrSetup:  w_state_next = StWrPulse;
      StWrPulse: begin
        if (r_wait == WrLast) w_state_next = StWrHold;
        else                  w_wait_next  = r_wait + 2'd1;
      end
      StWrHold: w_state_next = StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ram_addr_o = (r_state == StIdle) ? ifAddr_i : r_addr;
    ram_ce_n   = w_active && (r_state != StIdle) && w_uart;
    ram_oe_n   = !(w_active && ((r_state == StIdle) || (w_rd_phase && !w_uart)));
    ram_we_n   = !(w_active && (r_state == StWrPulse) && !w_uart);
    uart_rdn   = !(w_active && w_rd_phase && w_uart_data);
    uart_wrn   = !(w_active && (r_state == StWrPulse) && w_uart_data);
    done_o     = (r_state == StDone);
  end

  assign ram_data_io = (w_active && w_wr_drive) ? r_wdata : 16'hzzzz;
  assign rData_o     = r_rdata;
  assign inst_o      = r_inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_wait  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_inst  <= NOP_INST;
    end else begin
      r_state <= w_state_next;
      r_wait  <= w_wait_next;
      if (w_leave_idle) begin
        r_addr  <= memAddr_i;
        r_wdata <= wData_i;
      end
      // The fetch in the cycle a data request wins the bus is discarded.
      r_inst <= ((r_state == StIdle) && !w_req) ? ram_data_io : NOP_INST;
      if (r_state == StRdSample) begin
        r_rdata <= w_uart_stat ? {14'b0, uart_data_ready, uart_tbre & uart_tsre}
                               : ram_data_io;
      end
    end
  end

endmodule

// File: tb/tb_mem_control.sv
// Directed bench for mem_control with SRAM/UART bus models and a queue of expected results.
module tb_mem_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] memAddr_i, wData_i, ifAddr_i;
  logic        rMem_i, wMem_i;
  logic [15:0] rData_o, inst_o, ram_addr_o;
  logic        done_o, ram_ce_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn;
  logic        uart_data_ready, uart_tbre, uart_tsre;
  wire  [15:0] ram_data_io;

  logic [15:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    int          lat;
    bit          rd;
  } exp_t;
  exp_t exp_q[$];

  int we_lows, wrn_lows, rdn_lows, ce_hi, nop_cnt, lat;

  always #5 clk = ~clk;

  mem_control dut (
    .clk             (clk),
    .rst             (rst),
    .memAddr_i       (memAddr_i),
    .wData_i         (wData_i),
    .rMem_i          (rMem_i),
    .wMem_i          (wMem_i),
    .rData_o         (rData_o),
    .done_o          (done_o),
    .ifAddr_i        (ifAddr_i),
    .inst_o          (inst_o),
    .ram_addr_o      (ram_addr_o),
    .ram_data_io     (ram_data_io),
    .ram_ce_n        (ram_ce_n),
    .ram_oe_n        (ram_oe_n),
    .ram_we_n        (ram_we_n),
    .uart_rdn        (uart_rdn),
    .uart_wrn        (uart_wrn),
    .uart_data_ready (uart_data_ready),
    .uart_tbre       (uart_tbre),
    .uart_tsre       (uart_tsre)
  );

  assign ram_data_io = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr_o] :
                       (!uart_rdn) ? 16'h00A5 : 16'hzzzz;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n) mem[ram_addr_o] <= ram_data_io;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns once done_o has been seen (or the budget expires).
  task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                        input logic [15:0] wd, input logic [15:0] exp_data,
                        input int exp_lat);
    exp_t e;
    exp_q.push_back('{data: exp_data, lat: exp_lat, rd: rd});
    memAddr_i = addr;
    wData_i   = wd;
    rMem_i    = rd;
    wMem_i    = wr;
    we_lows = 0; wrn_lows = 0; rdn_lows = 0; ce_hi = 0; nop_cnt = 0; lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (!ram_we_n) we_lows++;
      if (!uart_wrn) wrn_lows++;
      if (!uart_rdn) rdn_lows++;
      if (ram_ce_n)  ce_hi++;
      if (inst_o == 16'h0800) nop_cnt++;
      if (done_o) begin
        lat = n;
        break;
      end
    end
    rMem_i = 1'b0;
    wMem_i = 1'b0;
    e = exp_q.pop_front();
    chk("latency", 32'(lat), 32'(e.lat));
    chk("nop_during_access", 32'(nop_cnt), 32'(e.lat));
    if (e.rd) chk("rdata", {16'h0, rData_o}, {16'h0, e.data});
    @(negedge clk);
    chk("done_single_pulse", {31'h0, done_o}, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'h6A05;
    mem[16'h8000] = 16'h1234;
    rst = 1'b0;
    memAddr_i = '0; wData_i = '0; ifAddr_i = '0; rMem_i = 1'b0; wMem_i = 1'b0;
    uart_data_ready = 1'b0; uart_tbre = 1'b1; uart_tsre = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_inst", {16'h0, inst_o}, 32'h0800);
    chk("rst_done", {31'h0, done_o}, 32'h0);
    chk("rst_rdata", {16'h0, rData_o}, 32'h0);
    chk("rst_ce_n", {31'h0, ram_ce_n}, 32'h0);
    chk("rst_oe_n", {31'h0, ram_oe_n}, 32'h1);
    chk("rst_we_n", {31'h0, ram_we_n}, 32'h1);
    chk("rst_uart_rdn", {31'h0, uart_rdn}, 32'h1);
    chk("rst_uart_wrn", {31'h0, uart_wrn}, 32'h1);

    rst = 1'b1;
    ifAddr_i = 16'h0010;
    @(negedge clk);
    chk("fetch_inst", {16'h0, inst_o}, 32'h6A05);
    chk("fetch_oe_n", {31'h0, ram_oe_n}, 32'h0);
    chk("fetch_addr", {16'h0, ram_addr_o}, 32'h0010);

    access(1'b1, 1'b0, 16'h8000, 16'h0000, 16'h1234, 3);
    chk("load_no_we", 32'(we_lows), 32'h0);

    access(1'b0, 1'b1, 16'h8001, 16'hBEEF, 16'h0000, 4);
    chk("store_we_pulse", 32'(we_lows), 32'h1);
    chk("store_mem", {16'h0, mem[16'h8001]}, 32'hBEEF);
    chk("rdata_held", {16'h0, rData_o}, 32'h1234);

    access(1'b1, 1'b0, 16'h8001, 16'h0000, 16'hBEEF, 3);

    access(1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0001, 3);
    chk("stat_ce_n_high", 32'(ce_hi), 32'h3);
    chk("stat_no_rdn", 32'(rdn_lows), 32'h0);

    uart_data_ready = 1'b1;
    uart_tsre = 1'b0;
    access(1'b1, 1'b0, 16'hBF01, 16'h0000, 16'h0002, 3);

    access(1'b1, 1'b0, 16'hBF00, 16'h0000, 16'h00A5, 3);
    chk("uart_rd_rdn_low", 32'(rdn_lows), 32'h2);
    chk("uart_rd_ce_n_high", 32'(ce_hi), 32'h3);

    access(1'b0, 1'b1, 16'hBF00, 16'h0041, 16'h0000, 4);
    chk("uart_wr_wrn_pulse", 32'(wrn_lows), 32'h1);
    chk("uart_wr_no_we", 32'(we_lows), 32'h0);
    chk("uart_wr_rdata_held", {16'h0, rData_o}, 32'h00A5);

    access(1'b1, 1'b1, 16'h8000, 16'hDEAD, 16'h1234, 3);
    chk("conflict_no_we", 32'(we_lows), 32'h0);
    chk("conflict_mem_kept", {16'h0, mem[16'h8000]}, 32'h1234);
    @(negedge clk);
    chk("fetch_resumes", {16'h0, inst_o}, 32'h6A05);

    // Abort a store in the middle of its write pulse.
    memAddr_i = 16'h8002;
    wData_i   = 16'h5A5A;
    wMem_i    = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_abort_we_low", {31'h0, ram_we_n}, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("abort_we_n", {31'h0, ram_we_n}, 32'h1);
    chk("abort_oe_n", {31'h0, ram_oe_n}, 32'h1);
    chk("abort_done", {31'h0, done_o}, 32'h0);
    wMem_i = 1'b0;
    @(negedge clk);
    chk("abort_inst", {16'h0, inst_o}, 32'h0800);
    chk("abort_rdata", {16'h0, rData_o}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_idle_oe", {31'h0, ram_oe_n}, 32'h0);
    chk("post_abort_idle_addr", {16'h0, ram_addr_o}, 32'h0010);
    chk("post_abort_no_done", {31'h0, done_o}, 32'h0);
    chk("abort_no_write", {16'h0, mem[16'h8002]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
